riscv_lsu: RTL
==============

# riscv_lsu

Load-store unit between `riscv_core`'s data port and data memory. Accepts the core's single-cycle memory request (`mem_req_o`/`mem_we_o`/`mem_size_o`/`mem_addr_o`/`mem_wd_o`) and produces byte enables and replicated write data. Holds the core via `stall_i` until memory signals completion, then returns sign- or zero-extended load data to the core's `mem_rd_i`. Also detects misaligned accesses and memory timeouts.

## Interface
- `TIMEOUT`, 255: cycles in BUSY without `mem_ready_i` before the access is aborted. 0 disables the watchdog.
- `clk_i`  in  1  clock
- `rst_i`  in  1  synchronous, active-high reset
- `core_req_i`  in  1  access request from core
- `core_we_i`  in  1  1 = store, 0 = load
- `core_size_i`  in  3  funct3 size code (LDST_B/H/W/BU/HU)
- `core_addr_i`  in  32  byte address
- `core_wd_i`  in  32  store data (LSBs significant)
- `core_rd_o`  out  32  extended load data
- `core_stall_o`  out  1  to core `stall_i`
- `misalign_o`  out  1  pulse: misaligned or illegal-size request rejected
- `timeout_o`  out  1  pulse: access aborted by watchdog
- `mem_req_o`  out  1  memory request
- `mem_we_o`  out  1  memory write enable
- `mem_be_o`  out  4  byte enables
- `mem_addr_o`  out  32  `{core_addr_i[31:2], 2'b00}`
- `mem_wd_o`  out  32  replicated write data
- `mem_rd_i`  in  32  memory word read data
- `mem_ready_i`  in  1  access complete; `mem_rd_i` valid this cycle

## Operation
- FSM: IDLE, BUSY.
- Size codes: B=0, H=1, W=2, BU=4, HU=5. Codes 3, 6 and 7 are illegal.
- Misaligned request: H/HU with `addr[0]`=1, or W with `addr[1:0]`≠0.
- Byte enables:
  - B/BU: `4'b0001 << addr[1:0]`
  - H/HU: `addr[1] ? 1100 : 0011`
  - W: `1111`
- Write data:
  - B: `{4{wd[7:0]}}`
  - H: `{2{wd[15:0]}}`
  - W: `wd`
- Read data: select the byte (`addr[1:0]`) or half (`addr[1]`) of `mem_rd_i`.
  - B/H: sign-extend.
  - BU/HU: zero-extend.
  - W: pass through.
- IDLE, `core_req_i`=1, legal and aligned:
  - `mem_req_o`=1 and `core_stall_o`=1, both combinational.
  - Next state BUSY; watchdog counter cleared.
- IDLE, `core_req_i`=1, misaligned or illegal:
  - `misalign_o`=1 for that cycle.
  - No memory request; `core_stall_o`=0; `core_rd_o`=0; stay in IDLE.
- BUSY:
  - `mem_req_o`=1 and `mem_we_o`=`core_we_i`.
  - `core_stall_o`=`~mem_ready_i`; counter increments.
  - `mem_ready_i`=1: `core_rd_o` valid combinationally, next state IDLE.
  - Counter reaches TIMEOUT (nonzero) without ready: `timeout_o`=1 and `core_stall_o`=0 that cycle, `core_rd_o`=0, next state IDLE.
- `mem_ready_i` is ignored in IDLE.
- `core_req_i` dropping while in BUSY: the access still completes; the result is discarded.
- `mem_we_o`=`core_we_i & mem_req_o`. When `mem_req_o`=0, `mem_be_o`=0.

## Timing
- Minimum access: 2 cycles (IDLE request cycle, BUSY ready cycle). `core_stall_o` is high for exactly 1 cycle.
- Back-to-back accesses: the core advances on the ready edge; the next request is seen in IDLE the following cycle. No bubble beyond the 2-cycle minimum.
- Register writeback: the core writes the load result at the edge where `core_stall_o`=0, so `core_rd_o` must be valid in the ready cycle.
- While `rst_i`=1, the following are forced to 0 combinationally: `mem_req_o`, `mem_we_o`, `core_stall_o`, `misalign_o`, `timeout_o`.
- Next cycle after reset: state IDLE, counter 0.
- Reset in BUSY aborts the access; no `timeout_o`.
- The core holds all `core_*` inputs stable while stalled, so the LSU registers only state and counter.

## Structure
- Size constants `LDST_B`, `LDST_H`, `LDST_W`, `LDST_BU`, `LDST_HU` and `lsu_state_t` (IDLE, BUSY) go in the shared `riscv_pkg`.
- One combinational sub-module, `lsu_data_align`, computes byte enables, write replication, read extraction and the misalign flag.
- `riscv_lsu` holds the FSM, watchdog counter and output gating.
- Counter width: `$clog2(TIMEOUT+1)`, minimum 1.

## Test plan
- SB to 0x103, wd=0x000000A5, ready in cycle 2: `mem_be_o`=1000, `mem_wd_o`=0xA5A5A5A5, `mem_addr_o`=0x100, stall high 1 cycle.
- LH from 0x202, `mem_rd_i`=0x8001_1234: `core_rd_o`=0xFFFF8001. Repeat as LHU: 0x00008001.
- LB/LBU from 0x1, `mem_rd_i`=0x0000F000: `core_rd_o`=0xFFFFFFF0 / 0x000000F0. LW, 3 wait cycles: stall high 4 cycles, `core_rd_o`=`mem_rd_i`.
- LW to 0x6, then SH to 0x1, then size=3: `misalign_o` pulses each time; `mem_req_o` stays 0; stall stays 0.
- TIMEOUT=4, no ready: `timeout_o` pulses 4 cycles after entering BUSY, stall drops, FSM returns to IDLE.
- `rst_i` asserted in BUSY: next cycle IDLE, `mem_req_o`=0; a later `mem_ready_i` is ignored; back-to-back SW then LW both complete in 2 cycles each.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared core definitions used by the load-store unit.
//   LDST_*       funct3 size codes for loads and stores
//   lsu_state_t  LSU access state (idle / waiting on memory)
package riscv_pkg;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic [0:0] {
    StIdle,
    StBusy
  } lsu_state_t;

endpackage

// File: rtl/lsu_data_align.sv
// Combinational data alignment for the LSU.
//   size_i     funct3 size code
//   addr_i     low two address bits
//   wd_i       store data from the core (LSBs significant)
//   rd_i       word read from memory
//   be_o       byte enables for the addressed lanes
//   wd_o       store data replicated across all lanes
//   rd_o       selected lane, sign- or zero-extended
//   misalign_o access is misaligned or the size code is illegal
module lsu_data_align
  import riscv_pkg::*;
(
  input  logic [2:0]  size_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wd_i,
  input  logic [31:0] rd_i,
  output logic [3:0]  be_o,
  output logic [31:0] wd_o,
  output logic [31:0] rd_o,
  output logic        misalign_o
);

  logic [4:0]  bit_off;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  assign bit_off = {addr_i, 3'b000};
  assign rd_byte = rd_i[bit_off +: 8];
  assign rd_half = addr_i[1] ? rd_i[31:16] : rd_i[15:0];

  always_comb begin
    be_o       = 4'b0000;
    wd_o       = wd_i;
    rd_o       = 32'h0;
    misalign_o = 1'b0;
    case (size_i)
      LDST_B, LDST_BU: begin
        be_o = 4'b0001 << addr_i;
        wd_o = {4{wd_i[7:0]}};
        rd_o = (size_i == LDST_B) ? {{24{rd_byte[7]}}, rd_byte} : {24'h0, rd_byte};
      end
      LDST_H, LDST_HU: begin
        misalign_o = addr_i[0];
        be_o       = addr_i[1] ? 4'b1100 : 4'b0011;
        wd_o       = {2{wd_i[15:0]}};
        rd_o       = (size_i == LDST_H) ? {{16{rd_half[15]}}, rd_half} : {16'h0, rd_half};
      end
      LDST_W: begin
        misalign_o = |addr_i;
        be_o       = 4'b1111;
        rd_o       = rd_i;
      end
      default: misalign_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// Load-store unit between the core data port and data memory.
//   clk_i, rst_i         clock, synchronous active-high reset
//   core_*               core request (held stable while stalled) and load result
//   core_stall_o         holds the core until the access finishes
//   misalign_o           pulse: request rejected (misaligned or illegal size)
//   timeout_o            pulse: access aborted by the watchdog
//   mem_*                word-addressed memory port with byte enables
// TIMEOUT: BUSY cycles without mem_ready_i before abort; 0 disables the watchdog.
module riscv_lsu
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        misalign_o,
  output logic        timeout_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  localparam int unsigned CntRaw = $clog2(TIMEOUT + 1);
  localparam int unsigned CntW   = (CntRaw < 1) ? 1 : CntRaw;
  localparam bit          WdogEn = (TIMEOUT != 0);
  // Counter is cleared on entry, so it holds TIMEOUT-1 in the TIMEOUT-th BUSY cycle.
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  lsu_state_t      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [3:0]  be_a;
  logic [31:0] wd_a;
  logic [31:0] rd_a;
  logic        bad_a;
  logic        mem_req;

  lsu_data_align u_align (
    .size_i     (core_size_i),
    .addr_i     (core_addr_i[1:0]),
    .wd_i       (core_wd_i),
    .rd_i       (mem_rd_i),
    .be_o       (be_a),
    .wd_o       (wd_a),
    .rd_o       (rd_a),
    .misalign_o (bad_a)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mem_req      = 1'b0;
    core_stall_o = 1'b0;
    misalign_o   = 1'b0;
    timeout_o    = 1'b0;
    core_rd_o    = 32'h0;
    case (state_q)
      StIdle: begin
        if (core_req_i) begin
          if (bad_a) begin
            misalign_o = 1'b1;
          end else begin
            mem_req      = 1'b1;
            core_stall_o = 1'b1;
            state_d      = StBusy;
            cnt_d        = '0;
          end
        end
      end
      StBusy: begin
        mem_req = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (mem_ready_i) begin
          core_rd_o = rd_a;
          state_d   = StIdle;
        end else if (WdogEn && (cnt_q == CntLast)) begin
          timeout_o = 1'b1;
          state_d   = StIdle;
        end else begin
          core_stall_o = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (rst_i) begin
      mem_req      = 1'b0;
      core_stall_o = 1'b0;
      misalign_o   = 1'b0;
      timeout_o    = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_req_o  = mem_req;
  assign mem_we_o   = core_we_i & mem_req;
  assign mem_be_o   = mem_req ? be_a : 4'b0000;
  assign mem_addr_o = {core_addr_i[31:2], 2'b00};
  assign mem_wd_o   = wd_a;

endmodule
